// File: rtl/pixel_plane_loader.sv
// pixel_plane_loader: splits a 24-bit RGB pixel stream into R/G/B planes, packing four
// pixels per channel into vector writes and flushing a short final group as scalar writes.
module pixel_plane_loader #(
    parameter int NUM_PIXELS = 40000,
    parameter int R_BASE     = 0,
    parameter int G_BASE     = 40000,
    parameter int B_BASE     = 80000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         pix_valid,
    input  logic [23:0]  pix_data,
    output logic         pix_ready,
    output logic [127:0] mem_addr,
    output logic [127:0] mem_wd,
    output logic         mem_we,
    output logic         mem_vf,
    output logic         busy,
    output logic         done
);
    typedef enum logic [2:0] {IDLE, FILL, WR_R, WR_G, WR_B, TAIL, DONE} state_t;
    localparam logic [15:0] NP = 16'(NUM_PIXELS);

    state_t       state_q, state_d;
    logic [2:0]   lane_q, lane_d, tk_q, tk_d;
    logic [1:0]   tch_q, tch_d, ch;
    logic [15:0]  pix_cnt_q, pix_cnt_d;
    logic [13:0]  grp_q, grp_d;
    logic [23:0]  pix_buf_q [4];
    logic [23:0]  pix_buf_d [4];
    logic         pix_ready_q, pix_ready_d, mem_we_q, mem_we_d, mem_vf_q, mem_vf_d;
    logic         busy_q, busy_d, done_q, done_d;
    logic [31:0]  addr_q, addr_d;
    logic [127:0] mem_wd_q, mem_wd_d;

    function automatic logic [7:0] chan_byte(input logic [23:0] p, input logic [1:0] c);
        return c == 2'd0 ? p[23:16] : c == 2'd1 ? p[15:8] : p[7:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            tk_q        <= '0;
            tch_q       <= '0;
            pix_cnt_q   <= '0;
            grp_q       <= '0;
            pix_buf_q   <= '{default: '0};
            pix_ready_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_vf_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            mem_wd_q    <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            tk_q        <= tk_d;
            tch_q       <= tch_d;
            pix_cnt_q   <= pix_cnt_d;
            grp_q       <= grp_d;
            pix_buf_q   <= pix_buf_d;
            pix_ready_q <= pix_ready_d;
            mem_we_q    <= mem_we_d;
            mem_vf_q    <= mem_vf_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            addr_q      <= addr_d;
            mem_wd_q    <= mem_wd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        tk_d      = tk_q;
        tch_d     = tch_q;
        pix_cnt_d = pix_cnt_q;
        grp_d     = grp_q;
        pix_buf_d = pix_buf_q;
        case (state_q)
            IDLE: if (start) begin
                state_d   = FILL;
                lane_d    = '0;
                pix_cnt_d = '0;
                grp_d     = '0;
            end
            FILL: if (pix_valid && pix_ready_q) begin
                pix_buf_d[lane_q[1:0]] = pix_data;
                lane_d    = lane_q + 3'd1;
                pix_cnt_d = pix_cnt_q + 16'd1;
                tk_d      = '0;
                tch_d     = '0;
                state_d   = lane_q == 3'd3 ? WR_R : pix_cnt_d == NP ? TAIL : FILL;
            end
            WR_R: state_d = WR_G;
            WR_G: state_d = WR_B;
            WR_B: begin
                grp_d   = grp_q + 14'd1;
                lane_d  = '0;
                state_d = pix_cnt_q == NP ? DONE : FILL;
            end
            // channel-major walk: all R lanes, then G, then B
            TAIL: begin
                tk_d    = tk_q == lane_q - 3'd1 ? 3'd0 : tk_q + 3'd1;
                tch_d   = tk_q == lane_q - 3'd1 ? tch_q + 2'd1 : tch_q;
                state_d = tk_q == lane_q - 3'd1 && tch_q == 2'd2 ? DONE : TAIL;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // outputs are computed from next-state values so they are registered yet aligned with the state
    always_comb begin
        ch          = state_d == WR_G ? 2'd1 : state_d == WR_B ? 2'd2 : state_d == TAIL ? tch_d : 2'd0;
        pix_ready_d = state_d == FILL;
        busy_d      = state_d != IDLE;
        done_d      = state_d == DONE;
        mem_vf_d    = state_d inside {WR_R, WR_G, WR_B};
        mem_we_d    = mem_vf_d || state_d == TAIL;
        addr_d      = '0;
        mem_wd_d    = '0;
        if (mem_we_d) begin
            addr_d = (ch == 2'd0 ? 32'(R_BASE) : ch == 2'd1 ? 32'(G_BASE) : 32'(B_BASE))
                   + {16'd0, grp_d, 2'b00} + (mem_vf_d ? 32'd0 : {29'd0, tk_d});
            if (mem_vf_d)
                for (int k = 0; k < 4; k++) mem_wd_d[32*k +: 8] = chan_byte(pix_buf_d[k], ch);
            else
                mem_wd_d[7:0] = chan_byte(pix_buf_d[tk_d[1:0]], ch);
        end
    end

    assign pix_ready = pix_ready_q;
    assign mem_addr  = {96'd0, addr_q};
    assign mem_wd    = mem_wd_q;
    assign mem_we    = mem_we_q;
    assign mem_vf    = mem_vf_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
